// File: rtl/spi_afe_pkg.sv
//------------------------------------------------------------------------------
// spi_afe_pkg
// Frame geometry and FSM encoding shared by the AFE link master and slave.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package spi_afe_pkg;

    localparam int FRAME_BITS = 24;
    localparam int CMD_BITS   = 8;
    localparam int DATA_BITS  = 16;

    localparam logic RW_READ = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic [4:0] bitcnt_inc(input logic [4:0] cnt);
        return (cnt == 5'd31) ? cnt : cnt + 5'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_afe_slave_if.sv
//------------------------------------------------------------------------------
// spi_afe_slave_if
// AFE serial link wires between the FPGA master and the responder.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface spi_afe_slave_if;
    logic spi_clk_i;
    logic spi_mosi_i;
    logic spi_sel_i;
    logic sel0_i;
    logic sel1_i;
    logic spi_miso_o;
    logic spi_miso_oe;

    modport master (
        output spi_clk_i, spi_mosi_i, spi_sel_i, sel0_i, sel1_i,
        input  spi_miso_o, spi_miso_oe
    );

    modport slave (
        input  spi_clk_i, spi_mosi_i, spi_sel_i, sel0_i, sel1_i,
        output spi_miso_o, spi_miso_oe
    );
endinterface

`default_nettype wire

// File: rtl/spi_afe_slave_in_sync.sv
//------------------------------------------------------------------------------
// spi_in_sync
// Two-flop synchroniser plus edge register for one asynchronous link input.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_in_sync #(
    parameter logic RST_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Reset to the idle line level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_LVL;
            r_sync <= RST_LVL;
            r_prev <= RST_LVL;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign level = r_sync;
    assign rise  = r_sync & ~r_prev;
    assign fall  = ~r_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_afe_slave.sv
//------------------------------------------------------------------------------
// spi_afe_slave
// SPI responder for the AFE link: 24-bit frames into a 16-bit register bank.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_afe_slave
    import spi_afe_pkg::*;
#(
    parameter logic [1:0]  CHAN_ID = 2'd0,
    parameter int          NREGS   = 16,
    parameter logic [15:0] RST_VAL = 16'h0
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    spi_afe_slave_if.slave        link,
    output logic [NREGS*16-1:0]   regs_o,
    output logic                  wr_strobe_o,
    output logic [6:0]            wr_addr_o,
    output logic                  frame_err_o
);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
    logic w_sel_lvl,  w_sel_rise,  w_sel_fall;
    logic w_s0_lvl,   w_s0_rise,   w_s0_fall;
    logic w_s1_lvl,   w_s1_rise,   w_s1_fall;

    spi_in_sync #(.RST_LVL(1'b0)) u_sync_sclk (.clk(sys_clk), .rst(sys_rst), .din(link.spi_clk_i),
        .level(w_sclk_lvl), .rise(w_sclk_rise), .fall(w_sclk_fall));
    spi_in_sync #(.RST_LVL(1'b0)) u_sync_mosi (.clk(sys_clk), .rst(sys_rst), .din(link.spi_mosi_i),
        .level(w_mosi_lvl), .rise(w_mosi_rise), .fall(w_mosi_fall));
    spi_in_sync #(.RST_LVL(1'b1)) u_sync_sel  (.clk(sys_clk), .rst(sys_rst), .din(link.spi_sel_i),
        .level(w_sel_lvl), .rise(w_sel_rise), .fall(w_sel_fall));
    spi_in_sync #(.RST_LVL(1'b0)) u_sync_s0   (.clk(sys_clk), .rst(sys_rst), .din(link.sel0_i),
        .level(w_s0_lvl), .rise(w_s0_rise), .fall(w_s0_fall));
    spi_in_sync #(.RST_LVL(1'b0)) u_sync_s1   (.clk(sys_clk), .rst(sys_rst), .din(link.sel1_i),
        .level(w_s1_lvl), .rise(w_s1_rise), .fall(w_s1_fall));

    logic w_unused_sync;
    assign w_unused_sync = ^{w_sclk_lvl, w_mosi_rise, w_mosi_fall, w_sel_lvl,
                             w_s0_rise, w_s0_fall, w_s1_rise, w_s1_fall};

    localparam logic [7:0] C_NREGS = 8'(NREGS);

    logic [1:0]          r_state;
    logic [4:0]          r_bitcnt;
    logic [23:0]         r_shin;
    logic                r_rw;
    logic [6:0]          r_addr;
    logic [15:0]         r_shout;
    logic                r_miso;
    logic                r_oe;
    logic                r_restart;
    logic [NREGS*16-1:0] r_regs;

    logic [23:0] w_shin_nxt;
    logic [6:0]  w_addr_nxt;
    logic        w_id_match;
    logic        w_in_range;
    logic        w_start;
    logic [15:0] w_rdata;

    assign w_shin_nxt = {r_shin[22:0], w_mosi_lvl};
    assign w_addr_nxt = w_shin_nxt[6:0];
    assign w_id_match = ({w_s1_lvl, w_s0_lvl} == CHAN_ID);
    assign w_in_range = ({1'b0, r_addr} < C_NREGS);
    // A frame opens from IDLE, or straight out of DONE when a select fall forced the close.
    assign w_start    = w_id_match && (((r_state == ST_IDLE) && w_sel_fall) ||
                                       ((r_state == ST_DONE) && r_restart));

    always_comb begin
        w_rdata = 16'h0;
        for (int k = 0; k < NREGS; k++) begin
            if (w_addr_nxt == 7'(k)) w_rdata = r_regs[16*k +: 16];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_bitcnt    <= 5'd0;
            r_shin      <= 24'h0;
            r_rw        <= 1'b0;
            r_addr      <= 7'd0;
            r_shout     <= 16'h0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_restart   <= 1'b0;
            r_regs      <= {NREGS{RST_VAL}};
            wr_strobe_o <= 1'b0;
            wr_addr_o   <= 7'd0;
            frame_err_o <= 1'b0;
        end else begin
            wr_strobe_o <= 1'b0;
            frame_err_o <= 1'b0;
            case (r_state)
                ST_CMD, ST_DATA: begin
                    // Select edges take priority over a coincident clock edge.
                    if (w_sel_rise || w_sel_fall) begin
                        r_state   <= ST_DONE;
                        r_oe      <= 1'b0;
                        r_miso    <= 1'b0;
                        r_restart <= w_sel_fall;
                    end else if (w_sclk_rise) begin
                        r_shin   <= w_shin_nxt;
                        r_bitcnt <= bitcnt_inc(r_bitcnt);
                        if ((r_state == ST_CMD) && (r_bitcnt == 5'(CMD_BITS - 1))) begin
                            r_rw    <= w_shin_nxt[7];
                            r_addr  <= w_addr_nxt;
                            r_shout <= (w_shin_nxt[7] == RW_READ) ? w_rdata : 16'h0;
                            r_state <= ST_DATA;
                        end
                    end else if (w_sclk_fall && (r_state == ST_DATA)) begin
                        r_miso  <= r_shout[DATA_BITS-1];
                        r_shout <= {r_shout[14:0], 1'b0};
                    end
                end
                ST_DONE: begin
                    r_restart <= 1'b0;
                    if (r_bitcnt != 5'(FRAME_BITS)) begin
                        frame_err_o <= 1'b1;
                    end else if (r_rw != RW_READ) begin
                        if (w_in_range) begin
                            for (int k = 0; k < NREGS; k++) begin
                                if (r_addr == 7'(k)) r_regs[16*k +: 16] <= r_shin[15:0];
                            end
                            wr_strobe_o <= 1'b1;
                            wr_addr_o   <= r_addr;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                    end
                    r_state <= ST_IDLE;
                end
                default: ;
            endcase
            if (w_start) begin
                r_state  <= ST_CMD;
                r_bitcnt <= 5'd0;
                r_shout  <= 16'h0;
                r_miso   <= 1'b0;
                r_oe     <= 1'b1;
            end
        end
    end

    assign regs_o           = r_regs;
    assign link.spi_miso_o  = r_miso;
    assign link.spi_miso_oe = r_oe;

endmodule

`default_nettype wire

// File: tb/tb_spi_afe_slave.sv
//------------------------------------------------------------------------------
// tb_spi_afe_slave
// Directed self-checking bench for spi_afe_slave (CHAN_ID 0, NREGS 16).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_afe_slave;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [255:0]  regs_o;
    logic          wr_strobe_o;
    logic [6:0]    wr_addr_o;
    logic          frame_err_o;

    spi_afe_slave_if link();

    spi_afe_slave #(.CHAN_ID(2'd0), .NREGS(16), .RST_VAL(16'h0)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .link        (link),
        .regs_o      (regs_o),
        .wr_strobe_o (wr_strobe_o),
        .wr_addr_o   (wr_addr_o),
        .frame_err_o (frame_err_o)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int strobe_cnt = 0;
    int err_cnt    = 0;
    logic oe_any = 1'b0;
    logic [255:0] exp_regs = '0;

    always @(negedge sys_clk) begin
        if (wr_strobe_o) strobe_cnt++;
        if (frame_err_o) err_cnt++;
        if (link.spi_miso_oe) oe_any = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // bits is left-aligned: bit 31 goes out first. abort_at >= 0 resets the DUT mid-frame.
    task automatic run_frame(input logic [31:0] bits, input int nbits, input logic [1:0] chan,
                             input int abort_at, output logic [31:0] rx, output logic mid_oe);
        rx = '0;
        mid_oe = 1'b0;
        oe_any = 1'b0;
        link.sel0_i = chan[0];
        link.sel1_i = chan[1];
        repeat (6) @(posedge sys_clk);
        link.spi_sel_i = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_at) begin
                sys_rst = 1'b1;
                repeat (2) @(posedge sys_clk);
                link.spi_sel_i = 1'b1;
                repeat (5) @(posedge sys_clk);
                sys_rst = 1'b0;
                repeat (10) @(posedge sys_clk);
                return;
            end
            link.spi_mosi_i = bits[31-i];
            repeat (8) @(posedge sys_clk);
            #1;
            rx[31-i] = link.spi_miso_o;
            if (i == 4) mid_oe = link.spi_miso_oe;
            link.spi_clk_i = 1'b1;
            repeat (8) @(posedge sys_clk);
            link.spi_clk_i = 1'b0;
        end
        repeat (8) @(posedge sys_clk);
        link.spi_sel_i = 1'b1;
        link.spi_mosi_i = 1'b0;
        repeat (20) @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (4) @(posedge sys_clk);
        #1;
        total++; if (regs_o !== 256'h0) begin bad++; $display("FAIL reset_regs: got %h want 0", regs_o); end
        total++; if (link.spi_miso_oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", link.spi_miso_oe); end
        total++; if (link.spi_miso_o !== 1'b0) begin bad++; $display("FAIL reset_miso: got %b want 0", link.spi_miso_o); end
        total++; if ({wr_strobe_o, frame_err_o, wr_addr_o} !== 9'h0) begin
            bad++; $display("FAIL reset_flags: got strobe=%b err=%b addr=%h want 0", wr_strobe_o, frame_err_o, wr_addr_o); end
        sys_rst = 1'b0;
        repeat (4) @(posedge sys_clk);
    endtask

    task automatic test_write;
        logic [31:0] rx; logic m; int s0, e0;
        s0 = strobe_cnt; e0 = err_cnt;
        run_frame({24'h05A5C3, 8'h0}, 24, 2'b00, -1, rx, m);
        exp_regs[5*16 +: 16] = 16'hA5C3;
        total++; if (strobe_cnt - s0 != 1) begin bad++; $display("FAIL write_strobe: got %0d pulses want 1", strobe_cnt - s0); end
        total++; if (wr_addr_o !== 7'd5) begin bad++; $display("FAIL write_addr: got %0d want 5", wr_addr_o); end
        total++; if (regs_o !== exp_regs) begin bad++; $display("FAIL write_regs: got %h want %h", regs_o, exp_regs); end
        total++; if (err_cnt != e0) begin bad++; $display("FAIL write_err: got %0d pulses want 0", err_cnt - e0); end
    endtask

    task automatic test_read;
        logic [31:0] rx; logic m; int s0, e0;
        s0 = strobe_cnt; e0 = err_cnt;
        run_frame({24'h850000, 8'h0}, 24, 2'b00, -1, rx, m);
        total++; if (rx[31:8] !== 24'h00A5C3) begin bad++; $display("FAIL read_miso: got %h want 00a5c3", rx[31:8]); end
        total++; if (m !== 1'b1) begin bad++; $display("FAIL read_oe_mid: got %b want 1", m); end
        total++; if (link.spi_miso_oe !== 1'b0) begin bad++; $display("FAIL read_oe_after: got %b want 0", link.spi_miso_oe); end
        total++; if ((strobe_cnt != s0) || (err_cnt != e0)) begin
            bad++; $display("FAIL read_side: got strobe=%0d err=%0d want 0 0", strobe_cnt - s0, err_cnt - e0); end
    endtask

    task automatic test_bad_length;
        logic [31:0] rx; logic m; int s0, e0;
        s0 = strobe_cnt; e0 = err_cnt;
        run_frame({24'h051111, 8'h0}, 20, 2'b00, -1, rx, m);
        total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL short_err: got %0d pulses want 1", err_cnt - e0); end
        total++; if (regs_o !== exp_regs) begin bad++; $display("FAIL short_regs: got %h want %h", regs_o, exp_regs); end
        e0 = err_cnt;
        run_frame({24'h05FFFF, 2'b11, 6'h0}, 26, 2'b00, -1, rx, m);
        total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL long_err: got %0d pulses want 1", err_cnt - e0); end
        total++; if ((regs_o !== exp_regs) || (strobe_cnt != s0)) begin
            bad++; $display("FAIL long_regs: got %h strobes=%0d want %h 0", regs_o, strobe_cnt - s0, exp_regs); end
    endtask

    task automatic test_mismatch;
        logic [31:0] rx; logic m; int s0, e0;
        s0 = strobe_cnt; e0 = err_cnt;
        run_frame({24'h057777, 8'h0}, 24, 2'b10, -1, rx, m);
        total++; if (oe_any !== 1'b0) begin bad++; $display("FAIL mismatch_oe: got %b want 0", oe_any); end
        total++; if ((strobe_cnt != s0) || (err_cnt != e0)) begin
            bad++; $display("FAIL mismatch_side: got strobe=%0d err=%0d want 0 0", strobe_cnt - s0, err_cnt - e0); end
        total++; if (regs_o !== exp_regs) begin bad++; $display("FAIL mismatch_regs: got %h want %h", regs_o, exp_regs); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] rx; logic m; int s0, e0;
        s0 = strobe_cnt; e0 = err_cnt;
        run_frame({24'h7F1234, 8'h0}, 24, 2'b00, -1, rx, m);
        total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL oor_err: got %0d pulses want 1", err_cnt - e0); end
        total++; if ((strobe_cnt != s0) || (regs_o !== exp_regs)) begin
            bad++; $display("FAIL oor_write: got strobes=%0d regs=%h want 0 %h", strobe_cnt - s0, regs_o, exp_regs); end
        run_frame({24'hFF0000, 8'h0}, 24, 2'b00, -1, rx, m);
        total++; if (rx[31:8] !== 24'h0) begin bad++; $display("FAIL oor_read: got %h want 000000", rx[31:8]); end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] rx; logic m; int s0, e0;
        run_frame({24'h035A5A, 8'h0}, 24, 2'b00, -1, rx, m);
        exp_regs[3*16 +: 16] = 16'h5A5A;
        total++; if (regs_o !== exp_regs) begin bad++; $display("FAIL pre_abort_regs: got %h want %h", regs_o, exp_regs); end
        s0 = strobe_cnt; e0 = err_cnt;
        run_frame({24'h03BEEF, 8'h0}, 24, 2'b00, 12, rx, m);
        exp_regs = '0;
        #1;
        total++; if (regs_o !== exp_regs) begin bad++; $display("FAIL abort_regs: got %h want 0", regs_o); end
        run_frame({24'h830000, 8'h0}, 24, 2'b00, -1, rx, m);
        total++; if (rx[31:8] !== 24'h0) begin bad++; $display("FAIL abort_read: got %h want 000000", rx[31:8]); end
        total++; if ((strobe_cnt != s0) || (err_cnt != e0)) begin
            bad++; $display("FAIL abort_side: got strobe=%0d err=%0d want 0 0", strobe_cnt - s0, err_cnt - e0); end
    endtask

    initial begin
        link.spi_clk_i  = 1'b0;
        link.spi_mosi_i = 1'b0;
        link.spi_sel_i  = 1'b1;
        link.sel0_i     = 1'b0;
        link.sel1_i     = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_bad_length();
        test_mismatch();
        test_out_of_range();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
